// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Bundles the pipeline status inputs and the stage-control
//                outputs of the hazard controller into one port group.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
    // Pipeline status seen by the controller
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        branch_taken;
    logic        jump;
    logic        imem_ready;
    logic        div_start;
    logic        clear_counters;

    // Stage control produced by the controller
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic [1:0]  state;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;

    // Pipeline side: drives status, observes control
    modport master (
        output id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, jump,
               imem_ready, div_start, clear_counters,
        input  pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
               ex_mem_flush, state, stall_cycles, flush_events
    );

    // Controller side
    modport slave (
        input  id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, jump,
               imem_ready, div_start, clear_counters,
        output pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
               ex_mem_flush, state, stall_cycles, flush_events
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Five-stage pipeline hazard controller. Resolves multi-cycle
//                divide stalls, load-use bubbles, branch/jump redirects and
//                instruction-memory waits, and keeps saturating stall/flush
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int DIV_LATENCY = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        DIV_BUSY = 2'b01
    } state_t;

    // Counter value loaded on divide entry; the entry cycle itself is the
    // first stall cycle, so DIV_BUSY lasts DIV_LATENCY-1 cycles.
    localparam logic [7:0]  C_DIV_RELOAD = 8'(DIV_LATENCY - 1);
    localparam logic [15:0] C_CNT_MAX    = 16'hFFFF;

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic        w_div_stall;
    logic        w_load_use;
    logic        w_redirect;

    logic        w_pc_write;
    logic        w_if_id_write;
    logic        w_id_ex_write;
    logic        w_if_id_flush;
    logic        w_id_ex_flush;
    logic        w_ex_mem_flush;

    // Hazard detection; register 0 is hard-wired and never creates a dependency
    always_comb begin
        w_div_stall = (state_q == DIV_BUSY) || bus.div_start;
        w_load_use  = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                      ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
        w_redirect  = bus.branch_taken || bus.jump;
    end

    // Prioritised stage control: divide > load-use > redirect > imem wait
    always_comb begin
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_id_ex_write  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        if (!rst) begin
            // Everything frozen while reset is held
        end else if (w_div_stall) begin
            w_ex_mem_flush = 1'b1;
        end else if (w_load_use) begin
            w_id_ex_write  = 1'b1;
            w_id_ex_flush  = 1'b1;
        end else if (w_redirect) begin
            w_pc_write     = 1'b1;
            w_if_id_write  = 1'b1;
            w_if_id_flush  = 1'b1;
        end else if (!bus.imem_ready) begin
            w_if_id_write  = 1'b1;
            w_if_id_flush  = 1'b1;
        end else begin
            w_pc_write     = 1'b1;
            w_if_id_write  = 1'b1;
            w_id_ex_write  = 1'b1;
        end
    end

    // Next-state for the divide sequencer and the performance counters
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            RUN: begin
                if (bus.div_start) begin
                    state_d   = DIV_BUSY;
                    div_cnt_d = C_DIV_RELOAD;
                end
            end
            DIV_BUSY: begin
                if (div_cnt_q <= 8'd1) begin
                    state_d   = RUN;
                    div_cnt_d = 8'd0;
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d   = RUN;
                div_cnt_d = 8'd0;
            end
        endcase

        if (bus.clear_counters) begin
            stall_cnt_d = 16'd0;
            flush_cnt_d = 16'd0;
        end else begin
            if (!w_pc_write && (stall_cnt_q != C_CNT_MAX))
                stall_cnt_d = stall_cnt_q + 16'd1;
            // Only a redirect that actually wins arbitration counts as a flush
            if (w_redirect && !w_div_stall && !w_load_use &&
                (flush_cnt_q != C_CNT_MAX))
                flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            div_cnt_q   <= 8'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.id_ex_write  = w_id_ex_write;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.ex_mem_flush = w_ex_mem_flush;
    assign bus.state        = state_q;
    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_events = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed bench for pipeline_hazard_ctrl (DIV_LATENCY = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    pipeline_hazard_ctrl_if hif ();

    pipeline_hazard_ctrl #(.DIV_LATENCY(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hif.id_rs          = 5'd0;
        hif.id_rt          = 5'd0;
        hif.ex_mem_read    = 1'b0;
        hif.ex_rt          = 5'd0;
        hif.branch_taken   = 1'b0;
        hif.jump           = 1'b0;
        hif.imem_ready     = 1'b1;
        hif.div_start      = 1'b0;
        hif.clear_counters = 1'b0;
    endtask

    // Checks the six stage-control outputs against a packed expectation
    // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush}
    task automatic chk_ctrl(input string tag, input logic [5:0] exp);
        chk(tag, {10'd0, hif.pc_write, hif.if_id_write, hif.id_ex_write,
                  hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush},
            {10'd0, exp});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        idle_inputs();

        // Reset state
        #3;
        chk_ctrl("reset_ctrl", 6'b000_000);
        chk("reset_state", {14'd0, hif.state}, 16'd0);
        chk("reset_stall", hif.stall_cycles, 16'd0);
        chk("reset_flush", hif.flush_events, 16'd0);
        #9 rst = 1'b1;            // release between edges
        tick();

        // Normal flow
        #1;
        chk_ctrl("normal", 6'b111_000);

        // Divide: entry cycle plus 7 busy cycles
        hif.div_start = 1'b1;
        #1;
        chk_ctrl("div_entry", 6'b000_001);
        chk("div_entry_state", {14'd0, hif.state}, 16'd0);
        tick();
        hif.div_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) hif.branch_taken = 1'b1;
            #1;
            chk($sformatf("div_busy_state_%0d", i), {14'd0, hif.state}, 16'd1);
            chk_ctrl($sformatf("div_busy_ctrl_%0d", i), 6'b000_001);
            tick();
        end
        hif.branch_taken = 1'b0;
        #1;
        chk("div_done_state", {14'd0, hif.state}, 16'd0);
        chk_ctrl("div_done_ctrl", 6'b111_000);
        chk("div_stall_cnt", hif.stall_cycles, 16'd8);
        chk("div_flush_cnt", hif.flush_events, 16'd0);

        // Load-use beats a taken branch
        hif.ex_mem_read  = 1'b1;
        hif.ex_rt        = 5'd5;
        hif.id_rt        = 5'd5;
        hif.branch_taken = 1'b1;
        #1;
        chk_ctrl("lu_over_branch", 6'b001_010);
        tick();
        chk("lu_over_branch_flush", hif.flush_events, 16'd0);
        chk("lu_over_branch_stall", hif.stall_cycles, 16'd9);

        // Load-use through rs
        idle_inputs();
        hif.ex_mem_read = 1'b1;
        hif.ex_rt       = 5'd3;
        hif.id_rs       = 5'd3;
        hif.id_rt       = 5'd7;
        #1;
        chk_ctrl("lu_rs", 6'b001_010);
        tick();
        chk("lu_rs_stall", hif.stall_cycles, 16'd10);

        // Load into r0 never stalls
        idle_inputs();
        hif.ex_mem_read = 1'b1;
        hif.ex_rt       = 5'd0;
        hif.id_rs       = 5'd0;
        #1;
        chk_ctrl("lu_r0", 6'b111_000);
        tick();
        chk("lu_r0_stall", hif.stall_cycles, 16'd10);

        // Branch wins over imem wait
        idle_inputs();
        hif.branch_taken = 1'b1;
        hif.imem_ready   = 1'b0;
        #1;
        chk_ctrl("branch_imem", 6'b110_100);
        tick();
        chk("branch_imem_flush", hif.flush_events, 16'd1);
        chk("branch_imem_stall", hif.stall_cycles, 16'd10);

        // Jump redirect
        idle_inputs();
        hif.jump = 1'b1;
        #1;
        chk_ctrl("jump", 6'b110_100);
        tick();
        chk("jump_flush", hif.flush_events, 16'd2);

        // Imem wait
        idle_inputs();
        hif.imem_ready = 1'b0;
        #1;
        chk_ctrl("imem_wait", 6'b010_100);
        tick();
        chk("imem_wait_stall", hif.stall_cycles, 16'd11);
        chk("imem_wait_flush", hif.flush_events, 16'd2);

        // Clear beats increment
        hif.clear_counters = 1'b1;
        tick();
        hif.clear_counters = 1'b0;
        chk("clear_stall", hif.stall_cycles, 16'd0);
        chk("clear_flush", hif.flush_events, 16'd0);

        // Saturation: drive stall counter to FFFE then past the top
        repeat (65534) tick();
        chk("sat_pre", hif.stall_cycles, 16'hFFFE);
        tick();
        chk("sat_first", hif.stall_cycles, 16'hFFFF);
        tick();
        tick();
        chk("sat_hold", hif.stall_cycles, 16'hFFFF);
        chk("sat_flush", hif.flush_events, 16'd0);
        hif.clear_counters = 1'b1;
        tick();
        hif.clear_counters = 1'b0;
        chk("sat_clear", hif.stall_cycles, 16'd0);

        // Reset in the middle of a divide stall
        idle_inputs();
        hif.div_start = 1'b1;
        tick();
        hif.div_start = 1'b0;
        repeat (3) tick();
        chk("mid_div_state", {14'd0, hif.state}, 16'd1);
        chk("mid_div_stall", hif.stall_cycles, 16'd4);
        #1 rst = 1'b0;
        #1;
        chk("rst_div_state", {14'd0, hif.state}, 16'd0);
        chk("rst_div_stall", hif.stall_cycles, 16'd0);
        chk_ctrl("rst_div_ctrl", 6'b000_000);
        #1 rst = 1'b1;
        #1;
        chk_ctrl("post_rst_ctrl", 6'b111_000);
        tick();
        chk("post_rst_state", {14'd0, hif.state}, 16'd0);
        chk_ctrl("post_rst_ctrl2", 6'b111_000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
